// File: rtl/seg7_pkg.sv
// Shared definitions for the multiplexed seven-segment scanner: scan states
// and the hex-to-segment table in active-high {g,f,e,d,c,b,a} form.
package seg7_pkg;

    typedef enum logic [1:0] {
        ST_DARK     = 2'd0,
        ST_GUARDING = 2'd1,
        ST_DRIVE    = 2'd2
    } seg7_state_e;

    localparam logic [6:0] SEG7_HEX [0:15] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] seg7_lookup(input logic [3:0] nibble);
        return SEG7_HEX[nibble];
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble-to-segment decoder; a blanked digit lights no segment.
// Polarity and registering are left to the scanner.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = seg7_lookup(i_nibble);
        if (i_blank) begin
            o_seg = 7'h00;
        end
    end

endmodule

// File: rtl/seg7_scan.sv
// Time-multiplexes a hex value across DIGITS seven-segment digits, one digit
// per scan strobe, with a frame shadow register and an all-dark guard gap.
module seg7_scan
    import seg7_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter int GUARD      = 1,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                tick,
    input  logic [4*DIGITS-1:0] value,
    input  logic [DIGITS-1:0]   dp_mask,
    input  logic                blank_lz,
    output logic [DIGITS-1:0]   an,
    output logic [6:0]          seg,
    output logic                dp
);

    localparam int               IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int               CNT_W    = $clog2(GUARD + 2);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(GUARD);

    seg7_state_e         r_state;
    seg7_state_e         w_state_next;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_idx_next;
    logic [4*DIGITS-1:0] r_shadow_val;
    logic [DIGITS-1:0]   r_shadow_dp;
    logic [CNT_W-1:0]    r_guard_cnt;
    logic                w_tick_acc;

    logic [3:0]          w_nibble;
    logic                w_blank;
    logic [6:0]          w_seg_dec;
    logic [DIGITS-1:0]   w_an;
    logic [6:0]          w_seg;
    logic                w_dp;
    logic [DIGITS-1:0]   r_an;
    logic [6:0]          r_seg;
    logic                r_dp;

    // Strobes landing inside the guard gap are dropped entirely.
    assign w_tick_acc = tick && (r_state != ST_GUARDING);

    always_comb begin
        w_idx_next = '0;
        if (r_state != ST_DARK && r_idx != IDX_LAST) begin
            w_idx_next = r_idx + IDX_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= ST_DARK;
        end else begin
            r_state <= w_state_next;
        end
    end

    // NOTE: default assignment first so no path leaves the output unassigned
    // and no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_DARK, ST_DRIVE: begin
                if (tick) begin
                    w_state_next = (GUARD > 0) ? ST_GUARDING : ST_DRIVE;
                end
            end
            ST_GUARDING: begin
                if (r_guard_cnt <= CNT_W'(1)) begin
                    w_state_next = ST_DRIVE;
                end
            end
            default: w_state_next = ST_DARK;
        endcase
    end

    // NOTE: the shadow registers are small and must read back as zero after
    // reset, so they sit on the async reset like any other flop.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_idx        <= '0;
            r_shadow_val <= '0;
            r_shadow_dp  <= '0;
            r_guard_cnt  <= '0;
        end else if (w_tick_acc) begin
            r_idx       <= w_idx_next;
            r_guard_cnt <= CNT_LOAD;
            if (w_idx_next == '0) begin
                r_shadow_val <= value;
                r_shadow_dp  <= dp_mask;
            end
        end else if (r_state == ST_GUARDING && r_guard_cnt != '0) begin
            r_guard_cnt <= r_guard_cnt - CNT_W'(1);
        end
    end

    assign w_nibble = r_shadow_val[{r_idx, 2'b00} +: 4];

    // A digit is a leading zero when it and every digit to its left are zero.
    always_comb begin
        w_blank = 1'b0;
        if (blank_lz && r_idx != '0) begin
            w_blank = ((r_shadow_val >> {r_idx, 2'b00}) == '0);
        end
    end

    seg7_hex_decode u_hex_decode (
        .i_nibble (w_nibble),
        .i_blank  (w_blank),
        .o_seg    (w_seg_dec)
    );

    always_comb begin
        w_an  = '0;
        w_seg = '0;
        w_dp  = 1'b0;
        if (r_state == ST_DRIVE) begin
            w_an[r_idx] = 1'b1;
            w_seg       = w_seg_dec;
            w_dp        = r_shadow_dp[r_idx];
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_an  <= {DIGITS{ACTIVE_LOW}};
            r_seg <= {7{ACTIVE_LOW}};
            r_dp  <= ACTIVE_LOW;
        end else begin
            r_an  <= w_an ^ {DIGITS{ACTIVE_LOW}};
            r_seg <= w_seg ^ {7{ACTIVE_LOW}};
            r_dp  <= w_dp ^ ACTIVE_LOW;
        end
    end

    assign an  = r_an;
    assign seg = r_seg;
    assign dp  = r_dp;

    a_an_onehot: assert property (@(posedge clk) disable iff (clr) $onehot0(w_an));

endmodule
